mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_latency_counter.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared types for the unified-memory port arbiter. Holds the
//                sequencer state encoding, the owner encoding and the fixed
//                data width of the memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_latency_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_latency_counter
//  Description : Down-counter that times the memory read latency. Loaded with
//                LATENCY-1 in the command cycle, decremented while waiting.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clock   in  system clock, rising edge
//    reset   in  synchronous active-high reset
//    load_i  in  load LATENCY-1 (has priority over dec_i)
//    dec_i   in  decrement by one, saturating at zero
//    zero_o  out the count being written this cycle is zero, i.e. the
//                counter expires at the coming edge
// ============================================================================
module arb_latency_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int            CW       = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Flag looks at the next value so the FSM can leave its current state in
   // the same cycle the count reaches zero (also covers LATENCY == 1, where
   // the loaded value is already zero).
   assign zero_o = (cnt_d == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : arb_latency_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port unified memory between instruction
//                fetch (read-only) and the MEM stage (load/store). Data wins
//                arbitration unless a fetch has waited MAX_DATA_BURST data
//                grants. Each access runs IDLE -> ISSUE -> WAIT* -> DONE.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clock, reset            clock and synchronous active-high reset
//    i_req/i_addr/i_cancel   fetch request, address and flush
//    i_ack/i_rdata           fetch completion pulse and instruction
//    d_req/d_we/d_addr/d_wdata  data request
//    d_ack/d_rdata           data completion pulse and load data
//    if_stall/mem_stall      stall indications to the pipeline
//    mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
// ============================================================================
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int LATENCY        = 2,
   parameter int MAX_DATA_BURST = 4,
   parameter int AW             = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [AW-1:0]     i_addr,
   input  logic              i_cancel,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [AW-1:0]     d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              if_stall,
   output logic              mem_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int            BW        = $clog2(MAX_DATA_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

   arb_state_e        state_q,     state_d;
   owner_e            owner_q,     owner_d;
   logic              op_we_q,     op_we_d;
   logic [BW-1:0]     burst_q,     burst_d;
   logic              cancel_q,    cancel_d;
   logic              mem_en_q,    mem_en_d;
   logic              mem_we_q,    mem_we_d;
   logic [AW-1:0]     mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

   logic lat_load;
   logic lat_dec;
   logic lat_zero;
   logic i_ack_c;
   logic d_ack_c;

   logic fetch_req;
   logic burst_full;
   logic fetch_win;
   logic data_win;

   arb_latency_counter #(
      .LATENCY (LATENCY)
   ) u_lat_cnt (
      .clock  (clock),
      .reset  (reset),
      .load_i (lat_load),
      .dec_i  (lat_dec),
      .zero_o (lat_zero)
   );

   // A fetch flushed in the grant cycle is simply not a candidate.
   assign fetch_req  = i_req & ~i_cancel;
   assign burst_full = (burst_q == BURST_MAX);
   assign fetch_win  = fetch_req & (~d_req | burst_full);
   assign data_win   = d_req & ~fetch_win;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      op_we_d     = op_we_q;
      burst_d     = burst_q;
      cancel_d    = cancel_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      lat_load    = 1'b0;
      lat_dec     = 1'b0;
      i_ack_c     = 1'b0;
      d_ack_c     = 1'b0;

      case (state_q)
         IDLE: begin
            if (fetch_win) begin
               owner_d    = OWN_I;
               op_we_d    = 1'b0;
               mem_addr_d = i_addr;
               mem_en_d   = 1'b1;
               burst_d    = '0;
               cancel_d   = 1'b0;
               state_d    = ISSUE;
            end else if (data_win) begin
               owner_d     = OWN_D;
               op_we_d     = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_en_d    = 1'b1;
               mem_we_d    = d_we;
               cancel_d    = 1'b0;
               state_d     = ISSUE;
               // Count data grants that overtake a waiting fetch.
               if (!i_req) begin
                  burst_d = '0;
               end else if (!burst_full) begin
                  burst_d = burst_q + BW'(1);
               end
            end else if (!i_req) begin
               burst_d = '0;
            end
         end

         ISSUE: begin
            lat_load = 1'b1;
            if ((owner_q == OWN_I) && i_cancel) begin
               cancel_d = 1'b1;
            end
            state_d = lat_zero ? DONE : WAIT;
         end

         WAIT: begin
            lat_dec = 1'b1;
            if ((owner_q == OWN_I) && i_cancel) begin
               cancel_d = 1'b1;
            end
            if (lat_zero) begin
               state_d = DONE;
            end
         end

         DONE: begin
            state_d  = IDLE;
            cancel_d = 1'b0;
            if (owner_q == OWN_D) begin
               d_ack_c = 1'b1;
               if (!op_we_q) begin
                  d_rdata_d = mem_rdata;
               end
            end else if (!cancel_q && !i_cancel) begin
               // A flushed fetch still completes on the memory, silently.
               i_ack_c   = 1'b1;
               i_rdata_d = mem_rdata;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_I;
         op_we_q     <= 1'b0;
         burst_q     <= '0;
         cancel_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         op_we_q     <= op_we_d;
         burst_q     <= burst_d;
         cancel_q    <= cancel_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   // Read data bypasses the holding register in the ack cycle, since the
   // memory result is only valid during DONE.
   assign i_ack     = i_ack_c;
   assign d_ack     = d_ack_c;
   assign i_rdata   = i_rdata_d;
   assign d_rdata   = d_rdata_d;
   assign if_stall  = i_req & ~i_ack_c & ~i_cancel;
   assign mem_stall = d_req & ~d_ack_c;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench. Instance dut uses LATENCY=2,
//                MAX_DATA_BURST=2; instance dut1 uses LATENCY=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int AW = 32;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic          i_req, i_cancel, i_ack, d_req, d_we, d_ack;
   logic          if_stall, mem_stall, mem_en, mem_we;
   logic [AW-1:0] i_addr, d_addr, mem_addr;
   logic [31:0]   i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

   logic          b_i_req, b_i_cancel, b_i_ack, b_d_req, b_d_we, b_d_ack;
   logic          b_if_stall, b_mem_stall, b_mem_en, b_mem_we;
   logic [AW-1:0] b_i_addr, b_d_addr, b_mem_addr;
   logic [31:0]   b_i_rdata, b_d_wdata, b_d_rdata, b_mem_wdata, b_mem_rdata;

   int vectors     = 0;
   int miscompares = 0;

   mem_port_arbiter #(.LATENCY(2), .MAX_DATA_BURST(2), .AW(AW)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
      .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .if_stall(if_stall), .mem_stall(mem_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.LATENCY(1), .MAX_DATA_BURST(4), .AW(AW)) dut1 (
      .clock(clock), .reset(reset),
      .i_req(b_i_req), .i_addr(b_i_addr), .i_cancel(b_i_cancel),
      .i_ack(b_i_ack), .i_rdata(b_i_rdata),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_ack(b_d_ack), .d_rdata(b_d_rdata),
      .if_stall(b_if_stall), .mem_stall(b_mem_stall),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      vectors++;
      if ({mem_en, mem_we, i_ack, d_ack, if_stall, mem_stall} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {mem_en, mem_we, i_ack, d_ack, if_stall, mem_stall});
      end
      vectors++;
      if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0) begin
         miscompares++;
         $display("FAIL reset_data: got %h %h %h %h expected all zero",
                  mem_addr, mem_wdata, i_rdata, d_rdata);
      end
      vectors++;
      if ({b_mem_en, b_mem_we, b_i_ack, b_d_ack, b_if_stall, b_mem_stall, b_mem_addr,
           b_mem_wdata, b_i_rdata, b_d_rdata} !== 134'h0) begin
         miscompares++;
         $display("FAIL reset_dut1: outputs not all zero (mem_en=%b d_rdata=%h)",
                  b_mem_en, b_d_rdata);
      end
      reset = 1'b0;
   endtask

   task automatic test_fetch();
      @(negedge clock);                                   // cycle t
      i_req = 1'b1; i_addr = 32'h40; mem_rdata = 32'h8C010004;
      #1;
      vectors++;
      if (if_stall !== 1'b1) begin
         miscompares++; $display("FAIL fetch_stall_t: got %b expected 1", if_stall);
      end
      @(negedge clock);                                   // t+1
      vectors++;
      if ({mem_en, mem_we, mem_addr, if_stall} !== {1'b1, 1'b0, 32'h40, 1'b1}) begin
         miscompares++;
         $display("FAIL fetch_issue: got en=%b we=%b addr=%h stall=%b expected 1 0 00000040 1",
                  mem_en, mem_we, mem_addr, if_stall);
      end
      @(negedge clock);                                   // t+2
      vectors++;
      if ({mem_en, i_ack, if_stall} !== 3'b001) begin
         miscompares++;
         $display("FAIL fetch_wait: got en/ack/stall=%b expected 001", {mem_en, i_ack, if_stall});
      end
      @(negedge clock);                                   // t+3
      vectors++;
      if ({i_ack, if_stall, i_rdata} !== {1'b1, 1'b0, 32'h8C010004}) begin
         miscompares++;
         $display("FAIL fetch_ack: got ack=%b stall=%b rdata=%h expected 1 0 8c010004",
                  i_ack, if_stall, i_rdata);
      end
      i_req = 1'b0;
      @(negedge clock);                                   // t+4
      vectors++;
      if ({i_ack, mem_en, i_rdata} !== {1'b0, 1'b0, 32'h8C010004}) begin
         miscompares++;
         $display("FAIL fetch_hold: got ack=%b en=%b rdata=%h expected 0 0 8c010004",
                  i_ack, mem_en, i_rdata);
      end
   endtask

   task automatic test_priority();
      @(negedge clock);                                   // cycle t
      i_req = 1'b1; i_addr = 32'h44;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
      mem_rdata = 32'h12345678;
      #1;
      vectors++;
      if ({if_stall, mem_stall} !== 2'b11) begin
         miscompares++; $display("FAIL prio_stall_t: got %b expected 11", {if_stall, mem_stall});
      end
      @(negedge clock);                                   // t+1
      vectors++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin
         miscompares++;
         $display("FAIL prio_store_issue: got en=%b we=%b addr=%h wdata=%h expected 1 1 00000100 deadbeef",
                  mem_en, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clock);                                   // t+2
      @(negedge clock);                                   // t+3
      vectors++;
      if ({d_ack, i_ack, mem_stall, if_stall} !== 4'b1001) begin
         miscompares++;
         $display("FAIL prio_store_ack: got dack/iack/mstall/istall=%b expected 1001",
                  {d_ack, i_ack, mem_stall, if_stall});
      end
      vectors++;
      if (d_rdata !== 32'h0) begin
         miscompares++; $display("FAIL prio_store_rdata_hold: got %h expected 00000000", d_rdata);
      end
      d_req = 1'b0; d_we = 1'b0; mem_rdata = 32'h24210002;
      @(negedge clock);                                   // t+4
      vectors++;
      if (mem_en !== 1'b0) begin
         miscompares++; $display("FAIL prio_idle_gap: got mem_en=%b expected 0", mem_en);
      end
      @(negedge clock);                                   // t+5
      vectors++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h44}) begin
         miscompares++;
         $display("FAIL prio_fetch_issue: got en=%b we=%b addr=%h expected 1 0 00000044",
                  mem_en, mem_we, mem_addr);
      end
      @(negedge clock);                                   // t+6
      @(negedge clock);                                   // t+7
      vectors++;
      if ({i_ack, d_ack, i_rdata} !== {1'b1, 1'b0, 32'h24210002}) begin
         miscompares++;
         $display("FAIL prio_fetch_ack: got iack=%b dack=%b rdata=%h expected 1 0 24210002",
                  i_ack, d_ack, i_rdata);
      end
      i_req = 1'b0;
   endtask

   task automatic test_burst();
      logic exp_d [6];
      int   n;
      exp_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      n = 0;
      @(negedge clock);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      i_req = 1'b1; i_addr = 32'h300; mem_rdata = 32'hCAFE0000;
      for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
         @(negedge clock);
         if (mem_en) begin
            vectors++;
            if ((mem_addr == 32'h200) !== exp_d[n]) begin
               miscompares++;
               $display("FAIL burst_order[%0d]: got data=%b expected data=%b",
                        n, (mem_addr == 32'h200), exp_d[n]);
            end
            n++;
         end
      end
      vectors++;
      if (n !== 6) begin
         miscompares++; $display("FAIL burst_timeout: got %0d grants expected 6", n);
      end
      d_req = 1'b0; i_req = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_cancel_idle();
      @(negedge clock);
      i_req = 1'b1; i_cancel = 1'b1; i_addr = 32'h70;
      #1;
      vectors++;
      if (if_stall !== 1'b0) begin
         miscompares++; $display("FAIL cancel_idle_stall: got %b expected 0", if_stall);
      end
      @(negedge clock);
      vectors++;
      if (mem_en !== 1'b0) begin
         miscompares++; $display("FAIL cancel_idle_grant: got mem_en=%b expected 0", mem_en);
      end
      i_req = 1'b0; i_cancel = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_cancel_wait();
      int en_cnt;
      en_cnt = 0;
      @(negedge clock);                                   // cycle t
      i_req = 1'b1; i_addr = 32'h60; mem_rdata = 32'h0BAD0BAD;
      @(negedge clock);                                   // t+1
      en_cnt += int'(mem_en);
      @(negedge clock);                                   // t+2, WAIT
      en_cnt += int'(mem_en);
      i_cancel = 1'b1; i_req = 1'b0;
      @(posedge clock);
      #1 i_cancel = 1'b0;
      @(negedge clock);                                   // t+3, DONE
      en_cnt += int'(mem_en);
      vectors++;
      if ({i_ack, i_rdata} !== {1'b0, 32'hCAFE0000}) begin
         miscompares++;
         $display("FAIL cancel_suppress: got ack=%b rdata=%h expected 0 cafe0000", i_ack, i_rdata);
      end
      @(negedge clock);                                   // t+4, IDLE
      en_cnt += int'(mem_en);
      vectors++;
      if (en_cnt !== 1) begin
         miscompares++; $display("FAIL cancel_mem_en_count: got %0d expected 1", en_cnt);
      end
      i_req = 1'b1; i_addr = 32'h80; mem_rdata = 32'h8C020008;
      @(negedge clock);                                   // t+5
      vectors++;
      if ({mem_en, mem_addr} !== {1'b1, 32'h80}) begin
         miscompares++;
         $display("FAIL cancel_refetch_issue: got en=%b addr=%h expected 1 00000080", mem_en, mem_addr);
      end
      repeat (2) @(negedge clock);                        // t+7
      vectors++;
      if ({i_ack, i_rdata} !== {1'b1, 32'h8C020008}) begin
         miscompares++;
         $display("FAIL cancel_refetch_ack: got ack=%b rdata=%h expected 1 8c020008", i_ack, i_rdata);
      end
      i_req = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset_mid();
      @(negedge clock);                                   // cycle t
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180; mem_rdata = 32'hBADBAD00;
      @(negedge clock);                                   // t+1
      @(negedge clock);                                   // t+2, WAIT
      reset = 1'b1;
      @(negedge clock);                                   // t+3
      vectors++;
      if ({i_ack, d_ack, mem_en, d_rdata, mem_addr} !== {3'b000, 32'h0, 32'h0}) begin
         miscompares++;
         $display("FAIL reset_mid: got iack=%b dack=%b en=%b rdata=%h addr=%h expected 0 0 0 0 0",
                  i_ack, d_ack, mem_en, d_rdata, mem_addr);
      end
      reset = 1'b0; d_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         vectors++;
         if ({d_ack, mem_en, d_rdata} !== {2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_mid_after[%0d]: got dack=%b en=%b rdata=%h expected 0 0 0",
                     c, d_ack, mem_en, d_rdata);
         end
      end
   endtask

   task automatic test_back_to_back();
      int   en_cyc [2];
      int   en_n;
      int   acks;
      logic prev_ack;
      en_n = 0; acks = 0; prev_ack = 1'b0;
      en_cyc = '{0, 0};
      @(negedge clock);                                   // c0
      b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h10; b_mem_rdata = 32'h0000AAAA;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         if (b_mem_en) begin
            vectors++;
            if (b_mem_addr !== ((en_n == 0) ? 32'h10 : 32'h14)) begin
               miscompares++;
               $display("FAIL b2b_addr[%0d]: got %h expected %h",
                        en_n, b_mem_addr, (en_n == 0) ? 32'h10 : 32'h14);
            end
            if (en_n < 2) en_cyc[en_n] = c;
            en_n++;
         end
         vectors++;
         if ((prev_ack & b_d_ack) !== 1'b0) begin
            miscompares++; $display("FAIL b2b_ack_consecutive: got 1 expected 0 at cycle %0d", c);
         end
         prev_ack = b_d_ack;
         if (b_d_ack) begin
            acks++;
            vectors++;
            if (b_d_rdata !== ((acks == 1) ? 32'h0000AAAA : 32'h0000BBBB)) begin
               miscompares++;
               $display("FAIL b2b_rdata[%0d]: got %h expected %h",
                        acks, b_d_rdata, (acks == 1) ? 32'h0000AAAA : 32'h0000BBBB);
            end
            if (acks == 1) begin
               b_d_addr = 32'h14; b_mem_rdata = 32'h0000BBBB;
            end else begin
               b_d_req = 1'b0;
            end
         end
      end
      vectors++;
      if ((en_n !== 2) || (en_cyc[1] - en_cyc[0] !== 3)) begin
         miscompares++;
         $display("FAIL b2b_spacing: got %0d commands spaced %0d expected 2 spaced 3",
                  en_n, en_cyc[1] - en_cyc[0]);
      end
      vectors++;
      if (acks !== 2) begin
         miscompares++; $display("FAIL b2b_ack_count: got %0d expected 2", acks);
      end
   endtask

   initial begin
      reset = 1'b1;
      i_req = 1'b0; i_cancel = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      b_i_req = 1'b0; b_i_cancel = 1'b0; b_i_addr = '0;
      b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0; b_mem_rdata = '0;

      test_reset();
      test_fetch();
      test_priority();
      test_burst();
      test_cancel_idle();
      test_cancel_wait();
      test_reset_mid();
      test_back_to_back();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t expected finish", $time);
      $fatal(1);
   end

endmodule : tb_mem_port_arbiter
`default_nettype wire
